// File: rtl/directory_controller.sv
// Home-node coherence directory: tracks U/S/E state and sharers per block,
// issues fetch/invalidate commands to L1s and replies with block data.
module directory_controller #(
    parameter int NUM_CACHES = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int SRC_W      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SRC_W-1:0]      req_src,
    input  logic [1:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  cmd_valid,
    output logic [NUM_CACHES-1:0] cmd_dest,
    output logic [1:0]            cmd_op,
    output logic [ADDR_W-1:0]     cmd_addr,
    input  logic [NUM_CACHES-1:0] ack_valid,
    input  logic [DATA_W-1:0]     ack_data,
    output logic                  reply_valid,
    output logic [SRC_W-1:0]      reply_dest,
    output logic [DATA_W-1:0]     reply_data
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, CMD, WAIT_ACK, REPLY} state_t;
    typedef enum logic [1:0] {DIR_U, DIR_S, DIR_E} dir_t;
    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t state, stateNext;
    req_t   req;

    dir_t                  dirState   [DEPTH];
    logic [NUM_CACHES-1:0] dirSharers [DEPTH];
    logic [DATA_W-1:0]     mem        [DEPTH];

    logic [NUM_CACHES-1:0] pending, pendingNext, fetchMask;
    dir_t                  newState;
    logic [NUM_CACHES-1:0] newSharers;
    logic                  doWb;
    logic [DATA_W-1:0]     replyBuf;
    logic                  ownerAck;

    // Lookup decision, valid while in LOOKUP
    dir_t                  curSt, lkSt;
    logic [NUM_CACHES-1:0] curSh, srcBit, others, lkMask, lkSh;
    logic [1:0]            lkOp;
    logic                  srcOk, isOwner, lkWb;
    logic [DATA_W-1:0]     lkReply;

    always_comb begin
        srcBit = '0;
        for (int i = 0; i < NUM_CACHES; i++)
            if (req.src == SRC_W'(i)) srcBit[i] = 1'b1;
        srcOk   = |srcBit;
        curSt   = dirState[req.addr];
        curSh   = dirSharers[req.addr];
        isOwner = (curSt == DIR_E) && (curSh == srcBit);
        others  = curSh & ~srcBit;
        lkMask  = '0;
        lkOp    = 2'b00;
        lkSt    = curSt;
        lkSh    = curSh;
        lkWb    = 1'b0;
        lkReply = mem[req.addr];
        case (req.op)
            2'b00: begin
                case (curSt)
                    DIR_U: begin lkSt = DIR_S; lkSh = srcBit; end
                    DIR_S: lkSh = curSh | srcBit;
                    default: if (!isOwner) begin
                        lkMask = curSh; lkOp = 2'b01; lkSt = DIR_S; lkSh = curSh | srcBit;
                    end
                endcase
            end
            2'b11: begin
                lkReply = '0;
                if (isOwner) begin lkWb = 1'b1; lkSt = DIR_U; lkSh = '0; end
            end
            default: begin
                // An upgrade only keeps its dataless reply when the requester still shares the block
                if (req.op == 2'b10 && curSt == DIR_S && (curSh & srcBit) != '0) begin
                    lkMask = others; lkOp = 2'b10; lkSt = DIR_E; lkSh = srcBit; lkReply = '0;
                end else begin
                    case (curSt)
                        DIR_U: begin lkSt = DIR_E; lkSh = srcBit; end
                        DIR_S: begin lkMask = others; lkOp = 2'b10; lkSt = DIR_E; lkSh = srcBit; end
                        default: if (!isOwner) begin
                            lkMask = curSh; lkOp = 2'b11; lkSt = DIR_E; lkSh = srcBit;
                        end
                    endcase
                end
            end
        endcase
    end

    assign pendingNext = pending & ~ack_valid;
    assign ownerAck    = (state == WAIT_ACK) && ((ack_valid & pending & fetchMask) != '0);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (req_valid && req_ready) stateNext = LOOKUP;
            LOOKUP:   if (!srcOk) stateNext = IDLE;
                      else if (lkMask != '0) stateNext = CMD;
                      else stateNext = REPLY;
            CMD:      stateNext = WAIT_ACK;
            WAIT_ACK: if (pendingNext == '0) stateNext = REPLY;
            REPLY:    stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_dest    <= '0;
            cmd_op      <= '0;
            cmd_addr    <= '0;
            reply_valid <= 1'b0;
            reply_dest  <= '0;
            reply_data  <= '0;
        end else begin
            state       <= stateNext;
            req_ready   <= (stateNext == IDLE);
            cmd_valid   <= (stateNext == CMD);
            cmd_dest    <= (stateNext == CMD) ? lkMask : '0;
            cmd_op      <= (stateNext == CMD) ? lkOp : 2'b00;
            cmd_addr    <= (stateNext == CMD) ? req.addr : '0;
            reply_valid <= (stateNext == REPLY);
            reply_dest  <= (stateNext == REPLY) ? req.src : '0;
            if (stateNext != REPLY)   reply_data <= '0;
            else if (state == LOOKUP) reply_data <= lkReply;
            else                      reply_data <= ownerAck ? ack_data : replyBuf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req        <= '0;
            pending    <= '0;
            fetchMask  <= '0;
            newState   <= DIR_U;
            newSharers <= '0;
            doWb       <= 1'b0;
            replyBuf   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dirState[i]   <= DIR_U;
                dirSharers[i] <= '0;
                mem[i]        <= '0;
            end
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready)
                    req <= '{src: req_src, op: req_op, addr: req_addr, data: req_data};
                LOOKUP: begin
                    newState   <= lkSt;
                    newSharers <= lkSh;
                    doWb       <= lkWb;
                    replyBuf   <= lkReply;
                    fetchMask  <= lkOp[0] ? lkMask : '0;
                end
                CMD: pending <= cmd_dest;
                WAIT_ACK: begin
                    pending <= pendingNext;
                    if (ownerAck) begin
                        mem[req.addr] <= ack_data;
                        replyBuf      <= ack_data;
                    end
                end
                REPLY: begin
                    dirState[req.addr]   <= newState;
                    dirSharers[req.addr] <= newSharers;
                    if (doWb) mem[req.addr] <= req.data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_directory_controller.sv
// Bench for directory_controller: directed vector table, hand-built corner
// sequences (ignored acks, reset mid-transaction) and random traffic vs a model.
module tb_directory_controller;
    logic       clk, rst_n;
    logic       req_valid, req_ready;
    logic [0:0] req_src;
    logic [1:0] req_op;
    logic [7:0] req_addr, req_data;
    logic       cmd_valid;
    logic [1:0] cmd_dest, cmd_op;
    logic [7:0] cmd_addr;
    logic [1:0] ack_valid;
    logic [7:0] ack_data;
    logic       reply_valid;
    logic [0:0] reply_dest;
    logic [7:0] reply_data;

    directory_controller #(.NUM_CACHES(2), .ADDR_W(8), .DATA_W(8), .SRC_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .cmd_valid(cmd_valid), .cmd_dest(cmd_dest), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .ack_valid(ack_valid), .ack_data(ack_data),
        .reply_valid(reply_valid), .reply_dest(reply_dest), .reply_data(reply_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0, nMis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference directory: state 0=U 1=S 2=E, sharer bit i = cache i
    int         mSt  [256];
    logic [1:0] mSh  [256];
    logic [7:0] mMem [256];

    task automatic modelReset();
        for (int i = 0; i < 256; i++) begin mSt[i] = 0; mSh[i] = 2'b00; mMem[i] = 8'h00; end
    endtask

    task automatic model(input logic s, input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] fv, output bit hasCmd, output logic [1:0] cDest,
                         output logic [1:0] cOp, output logic [7:0] rData);
        logic [1:0] me, sh;
        int st;
        bit own;
        me = s ? 2'b10 : 2'b01;
        sh = mSh[a];
        st = mSt[a];
        own = (st == 2) && (sh == me);
        cDest = 2'b00; cOp = 2'b00; rData = mMem[a];
        if (op == 2'd3) begin
            rData = 8'h00;
            if (own) begin mMem[a] = wd; mSt[a] = 0; mSh[a] = 2'b00; end
        end else if (op == 2'd2 && st == 1 && (sh & me) != 2'b00) begin
            cDest = sh & ~me; cOp = 2'b10; rData = 8'h00; mSt[a] = 2; mSh[a] = me;
        end else if (op == 2'd0) begin
            if (st == 0) begin mSt[a] = 1; mSh[a] = me; end
            else if (st == 1) mSh[a] = sh | me;
            else if (!own) begin
                cDest = sh; cOp = 2'b01; rData = fv; mMem[a] = fv; mSt[a] = 1; mSh[a] = sh | me;
            end
        end else begin
            if (st == 0) begin mSt[a] = 2; mSh[a] = me; end
            else if (st == 1) begin cDest = sh & ~me; cOp = 2'b10; mSt[a] = 2; mSh[a] = me; end
            else if (!own) begin
                cDest = sh; cOp = 2'b11; rData = fv; mMem[a] = fv; mSh[a] = me;
            end
        end
        hasCmd = (cDest != 2'b00);
        if (!hasCmd) cOp = 2'b00;
    endtask

    // One full transaction: request, optional command + acks, reply, return to idle.
    task automatic txn(input logic s, input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] fv, input bit hasCmd, input logic [1:0] cDest,
                       input logic [1:0] cOp, input logic [7:0] rData,
                       input int d0, input int d1, input int noiseCyc, input bit cmdAck);
        int guard, last;
        int dly[2];
        logic [1:0] ak;
        dly[0] = d0; dly[1] = d1;
        @(negedge clk);
        req_valid = 1'b1; req_src = s; req_op = op; req_addr = a; req_data = wd;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lookup_quiet", {29'd0, req_ready, cmd_valid, reply_valid}, 32'd0);
        @(negedge clk);
        chk("cmd_valid", 32'(cmd_valid), 32'(hasCmd));
        if (hasCmd && cmd_valid) begin
            chk("cmd_dest", 32'(cmd_dest), 32'(cDest));
            chk("cmd_op", 32'(cmd_op), 32'(cOp));
            chk("cmd_addr", 32'(cmd_addr), 32'(a));
            if (cmdAck) begin ack_valid = cDest; ack_data = 8'($urandom); end
            last = 0;
            for (int c = 0; c < 2; c++) if (cDest[c] && dly[c] > last) last = dly[c];
            for (int k = 0; k <= last; k++) begin
                @(negedge clk);
                if (k == 0) chk("cmd_pulse", 32'(cmd_valid), 32'd0);
                chk("early_reply", 32'(reply_valid), 32'd0);
                ak = 2'b00;
                for (int c = 0; c < 2; c++) if (cDest[c] && dly[c] == k) ak[c] = 1'b1;
                if (k == noiseCyc) ak = ak | ~cDest;
                ack_valid = ak;
                ack_data = (cOp[0] && (ak & cDest) != 2'b00) ? fv : 8'($urandom);
            end
            @(negedge clk);
            ack_valid = 2'b00;
        end
        chk("reply_valid", 32'(reply_valid), 32'd1);
        chk("reply_dest", 32'(reply_dest), 32'(s));
        chk("reply_data", 32'(reply_data), 32'(rData));
        @(negedge clk);
        chk("reply_pulse_ready", {30'd0, reply_valid, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic       s;
        logic [1:0] op;
        logic [7:0] a, wd, fv;
        bit         hasCmd;
        logic [1:0] cDest, cOp;
        logic [7:0] rData;
    } vec_t;

    vec_t tv[19];
    logic [7:0] addrs[4];

    initial begin
        bit hc;
        logic [1:0] cd, co;
        logic [7:0] rd;

        // op: 0 read miss, 1 write miss, 2 upgrade, 3 write-back
        tv[0]  = '{1'b0, 2'd0, 8'h12, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[1]  = '{1'b1, 2'd1, 8'h12, 8'h00, 8'h00, 1'b1, 2'b01, 2'b10, 8'h00};
        tv[2]  = '{1'b0, 2'd0, 8'h12, 8'h00, 8'hA5, 1'b1, 2'b10, 2'b01, 8'hA5};
        tv[3]  = '{1'b1, 2'd1, 8'h40, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[4]  = '{1'b1, 2'd3, 8'h40, 8'h3C, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[5]  = '{1'b1, 2'd1, 8'h40, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h3C};
        tv[6]  = '{1'b0, 2'd3, 8'h40, 8'h77, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[7]  = '{1'b1, 2'd0, 8'h40, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h3C};
        tv[8]  = '{1'b0, 2'd1, 8'h40, 8'h00, 8'h5E, 1'b1, 2'b10, 2'b11, 8'h5E};
        tv[9]  = '{1'b0, 2'd2, 8'h40, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h5E};
        tv[10] = '{1'b1, 2'd2, 8'h33, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[11] = '{1'b0, 2'd0, 8'h33, 8'h00, 8'h9C, 1'b1, 2'b10, 2'b01, 8'h9C};
        tv[12] = '{1'b0, 2'd1, 8'h33, 8'h00, 8'h00, 1'b1, 2'b10, 2'b10, 8'h9C};
        tv[13] = '{1'b1, 2'd0, 8'h55, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[14] = '{1'b1, 2'd2, 8'h55, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[15] = '{1'b0, 2'd0, 8'h66, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[16] = '{1'b1, 2'd2, 8'h66, 8'h00, 8'h00, 1'b1, 2'b01, 2'b10, 8'h00};
        tv[17] = '{1'b1, 2'd3, 8'h55, 8'h4D, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00};
        tv[18] = '{1'b0, 2'd0, 8'h55, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h4D};
        addrs = '{8'h12, 8'h13, 8'h40, 8'h41};

        rst_n = 1'b0; req_valid = 1'b0; req_src = 1'b0; req_op = 2'd0;
        req_addr = 8'h00; req_data = 8'h00; ack_valid = 2'b00; ack_data = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {8'd0, req_ready, cmd_valid, cmd_dest, cmd_op, cmd_addr,
                              reply_valid, reply_dest, reply_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        foreach (tv[i]) begin
            model(tv[i].s, tv[i].op, tv[i].a, tv[i].wd, tv[i].fv, hc, cd, co, rd);
            txn(tv[i].s, tv[i].op, tv[i].a, tv[i].wd, tv[i].fv, tv[i].hasCmd, tv[i].cDest,
                tv[i].cOp, tv[i].rData, 2, 1, -1, 1'b0);
        end

        // Upgrade from S{0,1}: ack during CMD ignored, acks held, stray ack from cache 0 ignored
        model(1'b0, 2'd2, 8'h12, 8'h00, 8'h00, hc, cd, co, rd);
        txn(1'b0, 2'd2, 8'h12, 8'h00, 8'h00, 1'b1, 2'b10, 2'b10, 8'h00, 0, 6, 5, 1'b1);

        // Reset while waiting on a fetch ack: no reply, directory and memory cleared
        @(negedge clk);
        req_valid = 1'b1; req_src = 1'b1; req_op = 2'd0; req_addr = 8'h12;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_cmd", {30'd0, cmd_valid, 1'b0} | 32'(cmd_dest == 2'b01), 32'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {8'd0, req_ready, cmd_valid, cmd_dest, cmd_op, cmd_addr,
                                 reply_valid, reply_dest, reply_data}, 32'd0);
        @(negedge clk);
        ack_valid = 2'b01; ack_data = 8'hEE;
        @(negedge clk);
        ack_valid = 2'b00;
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        chk("ready_after_midreset", {30'd0, req_ready, reply_valid}, 32'd2);
        model(1'b1, 2'd0, 8'h12, 8'h00, 8'h00, hc, cd, co, rd);
        txn(1'b1, 2'd0, 8'h12, 8'h00, 8'h00, hc, cd, co, rd, 1, 1, -1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic s;
            logic [1:0] op;
            logic [7:0] a, wd, fv;
            s  = 1'($urandom);
            op = 2'($urandom);
            a  = addrs[$urandom_range(0, 3)];
            wd = 8'($urandom);
            fv = 8'($urandom);
            model(s, op, a, wd, fv, hc, cd, co, rd);
            txn(s, op, a, wd, fv, hc, cd, co, rd, int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 6)) - 1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors so far", nVec);
        $fatal(1);
    end
endmodule
